crc_ctx_arbiter: RTL and testbench

- Shares one CRC32 custom-instruction engine between two software/hardware requesters, each with its own private 32-bit CRC context.
- The block drives the engine's clk_en/start/n/dataa/datab interface, waits for its done, and returns results to the requester.
- Context switches are lazy. When a different requester needs the engine, the block first reads out the outgoing owner's CRC (n=6), then loads the incoming owner's saved context (n=0), then executes the command.
- Sits between the two requester ports and the CRC engine instance.

---
 rtl/crc_ctx_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_crc_ctx_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_ctx_arbiter.sv
// Shares one CRC32 custom-instruction engine between two requesters, each with a private
// CRC context that is swapped in and out of the engine lazily on ownership change.
module crc_ctx_arbiter #(
    parameter logic [31:0] CTX_INIT     = 32'hFFFFFFFF,
    parameter int unsigned DONE_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_op,
    input  logic [2:0]  r0_len,
    input  logic [31:0] r0_dataa,
    input  logic [31:0] r0_datab,
    output logic        r0_rsp_valid,
    output logic [31:0] r0_rsp_data,
    output logic        r0_rsp_err,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_op,
    input  logic [2:0]  r1_len,
    input  logic [31:0] r1_dataa,
    input  logic [31:0] r1_datab,
    output logic        r1_rsp_valid,
    output logic [31:0] r1_rsp_data,
    output logic        r1_rsp_err,
    output logic        eng_clk_en,
    output logic        eng_start,
    output logic [2:0]  eng_n,
    output logic [31:0] eng_dataa,
    output logic [31:0] eng_datab,
    input  logic        eng_done,
    input  logic [31:0] eng_result,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_RESTORE = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_UPD = 2'b01;
    localparam logic [1:0] OP_GET = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [7:0] TMO_LAST = 8'(DONE_TIMEOUT - 1);

    logic [2:0]  state_q;
    logic [31:0] ctx0_q, ctx1_q;
    logic [1:0]  owner_q;
    logic        rr_q;
    logic        win_q;
    logic [2:0]  exec_n_q;
    logic [31:0] a_q, b_q;
    logic        eng_act_q, eng_first_q;
    logic [7:0]  tcnt_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        any_valid, arb_win, is_owner, bad_cmd;
    logic [1:0]  sel_op;
    logic [2:0]  sel_len;
    logic [31:0] sel_a, sel_b, win_ctx, cur_ctx;

    always_comb begin
        any_valid = r0_valid | r1_valid;
        arb_win   = (r0_valid & r1_valid) ? rr_q : r1_valid;
        sel_op    = arb_win ? r1_op    : r0_op;
        sel_len   = arb_win ? r1_len   : r0_len;
        sel_a     = arb_win ? r1_dataa : r0_dataa;
        sel_b     = arb_win ? r1_datab : r0_datab;
        win_ctx   = arb_win ? ctx1_q   : ctx0_q;
        cur_ctx   = win_q   ? ctx1_q   : ctx0_q;
        is_owner  = owner_q[1] && (owner_q[0] == arb_win);
        bad_cmd   = (sel_op == OP_RSV) ||
                    ((sel_op == OP_UPD) && ((sel_len == 3'd0) || (sel_len > 3'd5)));
    end

    // Engine drive is derived from the active-command flag so every field drops together.
    always_comb begin
        eng_clk_en = 1'b0;
        eng_start  = 1'b0;
        eng_n      = 3'd0;
        eng_dataa  = 32'h0;
        eng_datab  = 32'h0;
        if (eng_act_q) begin
            eng_clk_en = 1'b1;
            eng_start  = eng_first_q;
            case (state_q)
                S_SAVE:    eng_n = 3'd6;
                S_RESTORE: eng_dataa = cur_ctx;
                S_EXEC: begin
                    eng_n     = exec_n_q;
                    eng_dataa = a_q;
                    eng_datab = b_q;
                end
                default: ;
            endcase
        end
    end

    assign r0_ready     = (state_q == S_ARB) && any_valid && !arb_win;
    assign r1_ready     = (state_q == S_ARB) && any_valid &&  arb_win;
    assign r0_rsp_valid = (state_q == S_RESP) && !win_q;
    assign r1_rsp_valid = (state_q == S_RESP) &&  win_q;
    assign r0_rsp_data  = r0_rsp_valid ? rsp_data_q : 32'h0;
    assign r1_rsp_data  = r1_rsp_valid ? rsp_data_q : 32'h0;
    assign r0_rsp_err   = r0_rsp_valid & rsp_err_q;
    assign r1_rsp_err   = r1_rsp_valid & rsp_err_q;
    assign owner        = owner_q;
    assign busy         = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ctx0_q      <= CTX_INIT;
            ctx1_q      <= CTX_INIT;
            owner_q     <= 2'b00;
            rr_q        <= 1'b0;
            win_q       <= 1'b0;
            exec_n_q    <= 3'd0;
            a_q         <= 32'h0;
            b_q         <= 32'h0;
            eng_act_q   <= 1'b0;
            eng_first_q <= 1'b0;
            tcnt_q      <= 8'd0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (any_valid) state_q <= S_ARB;

                S_ARB: begin
                    if (!any_valid) begin
                        state_q <= S_IDLE;
                    end else begin
                        win_q     <= arb_win;
                        a_q       <= sel_a;
                        b_q       <= sel_b;
                        rr_q      <= ~arb_win;
                        rsp_err_q <= 1'b0;
                        if (bad_cmd) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= win_ctx;
                            state_q    <= S_RESP;
                        end else if ((sel_op == OP_SET) && !is_owner) begin
                            if (arb_win) ctx1_q <= sel_a;
                            else         ctx0_q <= sel_a;
                            rsp_data_q <= sel_a;
                            state_q    <= S_RESP;
                        end else if ((sel_op == OP_GET) && !is_owner) begin
                            rsp_data_q <= win_ctx;
                            state_q    <= S_RESP;
                        end else begin
                            // Owner commands go straight to the engine; others swap contexts first.
                            if (sel_op == OP_SET)      exec_n_q <= 3'd0;
                            else if (sel_op == OP_GET) exec_n_q <= 3'd6;
                            else                       exec_n_q <= sel_len;
                            if (is_owner)        state_q <= S_EXEC;
                            else if (owner_q[1]) state_q <= S_SAVE;
                            else                 state_q <= S_RESTORE;
                            eng_act_q   <= 1'b1;
                            eng_first_q <= 1'b1;
                            tcnt_q      <= 8'd0;
                        end
                    end
                end

                S_SAVE, S_RESTORE, S_EXEC: begin
                    if (!eng_act_q) begin
                        eng_act_q   <= 1'b1;
                        eng_first_q <= 1'b1;
                        tcnt_q      <= 8'd0;
                    end else begin
                        eng_first_q <= 1'b0;
                        if (eng_done) begin
                            eng_act_q <= 1'b0;
                            if (state_q == S_SAVE) begin
                                if (owner_q[0]) ctx1_q <= eng_result;
                                else            ctx0_q <= eng_result;
                                state_q <= S_RESTORE;
                            end else if (state_q == S_RESTORE) begin
                                owner_q <= {1'b1, win_q};
                                state_q <= S_EXEC;
                            end else begin
                                rsp_data_q <= (exec_n_q == 3'd0) ? a_q : eng_result;
                                state_q    <= S_RESP;
                            end
                        end else if (tcnt_q == TMO_LAST) begin
                            // Engine state is unknown after an abort, so nobody owns it.
                            eng_act_q  <= 1'b0;
                            owner_q    <= 2'b00;
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= 32'h0;
                            state_q    <= S_RESP;
                        end else begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                    end
                end

                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_ctx_arbiter.sv
// Scoreboard bench for crc_ctx_arbiter: a CRC32 engine model plus a reference model of
// contexts/ownership predicts grants, engine commands and responses.
module tb_crc_ctx_arbiter;

    localparam logic [31:0] CTX_INIT = 32'hFFFFFFFF;
    localparam int          TMO      = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [1:0]  r0_op = 2'b0, r1_op = 2'b0;
    logic [2:0]  r0_len = 3'd0, r1_len = 3'd0;
    logic [31:0] r0_dataa = 32'h0, r0_datab = 32'h0, r1_dataa = 32'h0, r1_datab = 32'h0;
    logic        r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
    logic [31:0] r0_rsp_data, r1_rsp_data;
    logic        eng_clk_en, eng_start, eng_done;
    logic [2:0]  eng_n;
    logic [31:0] eng_dataa, eng_datab, eng_result;
    logic [1:0]  owner;
    logic        busy;

    crc_ctx_arbiter #(.CTX_INIT(CTX_INIT), .DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_len(r0_len),
        .r0_dataa(r0_dataa), .r0_datab(r0_datab), .r0_rsp_valid(r0_rsp_valid),
        .r0_rsp_data(r0_rsp_data), .r0_rsp_err(r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_len(r1_len),
        .r1_dataa(r1_dataa), .r1_datab(r1_datab), .r1_rsp_valid(r1_rsp_valid),
        .r1_rsp_data(r1_rsp_data), .r1_rsp_err(r1_rsp_err),
        .eng_clk_en(eng_clk_en), .eng_start(eng_start), .eng_n(eng_n),
        .eng_dataa(eng_dataa), .eng_datab(eng_datab), .eng_done(eng_done),
        .eng_result(eng_result), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // New engine state after opcode n; the result returned at done equals this state.
    function automatic logic [31:0] eng_exec(input logic [2:0] n, input logic [31:0] s,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] w;
        r = s;
        w = {b, a};
        if (n == 3'd0) r = a;
        else if (n >= 3'd1 && n <= 3'd4) begin
            for (int i = 0; i < int'(n); i++) r = crc_byte(r, w[8*i +: 8]);
        end else if (n == 3'd5) begin
            for (int i = 0; i < 8; i++) r = crc_byte(r, w[8*i +: 8]);
        end
        return r;
    endfunction

    // ---------------- engine model ----------------
    bit          hang = 1'b0;
    bit          e_pend = 1'b0;
    int          e_cnt = 0;
    logic [2:0]  e_n = 3'd0;
    logic [31:0] e_a = 32'h0, e_b = 32'h0, e_state = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_done   <= 1'b0;
            eng_result <= 32'h0;
            e_pend     <= 1'b0;
        end else if (eng_clk_en && eng_start) begin
            e_pend   <= 1'b1;
            e_cnt    <= (eng_n == 3'd0 || eng_n == 3'd6) ? 1 : int'(eng_n);
            e_n      <= eng_n;
            e_a      <= eng_dataa;
            e_b      <= eng_datab;
            eng_done <= 1'b0;
        end else if (e_pend && eng_clk_en) begin
            if (e_cnt <= 1 && !hang) begin
                eng_done   <= 1'b1;
                e_pend     <= 1'b0;
                eng_result <= eng_exec(e_n, e_state, e_a, e_b);
                e_state    <= eng_exec(e_n, e_state, e_a, e_b);
            end else begin
                e_cnt <= e_cnt - 1;
            end
        end else begin
            eng_done <= 1'b0;
            if (!eng_clk_en) e_pend <= 1'b0;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] mctx [2];
    logic [1:0]  mown = 2'b00;
    logic [31:0] meng = 32'h0;
    bit          mrr = 1'b0;
    logic [32:0] exp_rsp0 [$];
    logic [32:0] exp_rsp1 [$];
    logic [34:0] exp_eng [$];
    bit          exp_grant [$];
    int          rsp_cnt [2];

    task automatic push_rsp(input bit k, input logic [32:0] v);
        if (k) exp_rsp1.push_back(v);
        else   exp_rsp0.push_back(v);
    endtask

    task automatic model_cmd(input bit k, input logic [1:0] op, input logic [2:0] len,
                             input logic [31:0] a, input logic [31:0] b, input bit tmo);
        bit          bad, own;
        logic [2:0]  n;
        exp_grant.push_back(k);
        mrr = !k;
        bad = (op == 2'b11) || (op == 2'b01 && (len == 3'd0 || len > 3'd5));
        own = mown[1] && (mown[0] == k);
        if (bad) push_rsp(k, {1'b1, mctx[k]});
        else if (op == 2'b00 && !own) begin
            mctx[k] = a;
            push_rsp(k, {1'b0, a});
        end else if (op == 2'b10 && !own) push_rsp(k, {1'b0, mctx[k]});
        else begin
            if (!own) begin
                if (mown[1]) begin
                    exp_eng.push_back({3'd6, 32'h0});
                    mctx[mown[0]] = meng;
                end
                exp_eng.push_back({3'd0, mctx[k]});
                meng = mctx[k];
                mown = {1'b1, k};
            end
            n = (op == 2'b00) ? 3'd0 : (op == 2'b10) ? 3'd6 : len;
            exp_eng.push_back({n, a});
            if (tmo) begin
                mown = 2'b00;
                push_rsp(k, {1'b1, 32'h0});
            end else begin
                meng = eng_exec(n, meng, a, b);
                push_rsp(k, {1'b0, meng});
            end
        end
    endtask

    bit prev_en = 1'b0;
    int run = 0;
    int last_run = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_en = 1'b0;
            run = 0;
        end else begin
            if (r0_ready || r1_ready) begin
                chk("ready_onehot", 32'(r0_ready & r1_ready), 32'd0);
                chk("grant_expected", 32'(exp_grant.size() > 0), 32'd1);
                if (exp_grant.size() > 0) chk("grant_winner", 32'(r1_ready), 32'(exp_grant.pop_front()));
            end
            if (r0_rsp_valid) begin
                logic [32:0] e;
                chk("rsp0_expected", 32'(exp_rsp0.size() > 0), 32'd1);
                if (exp_rsp0.size() > 0) begin
                    e = exp_rsp0.pop_front();
                    chk("rsp0_data", r0_rsp_data, e[31:0]);
                    chk("rsp0_err", 32'(r0_rsp_err), 32'(e[32]));
                end
                rsp_cnt[0]++;
            end
            if (r1_rsp_valid) begin
                logic [32:0] e;
                chk("rsp1_expected", 32'(exp_rsp1.size() > 0), 32'd1);
                if (exp_rsp1.size() > 0) begin
                    e = exp_rsp1.pop_front();
                    chk("rsp1_data", r1_rsp_data, e[31:0]);
                    chk("rsp1_err", 32'(r1_rsp_err), 32'(e[32]));
                end
                rsp_cnt[1]++;
            end
            if (eng_start) begin
                logic [34:0] e;
                chk("eng_gap", 32'(prev_en), 32'd0);
                chk("eng_expected", 32'(exp_eng.size() > 0), 32'd1);
                if (exp_eng.size() > 0) begin
                    e = exp_eng.pop_front();
                    chk("eng_n", 32'(eng_n), 32'(e[34:32]));
                    chk("eng_dataa", eng_dataa, e[31:0]);
                end
            end
            if (eng_clk_en) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            prev_en = eng_clk_en;
        end
    end

    // ---------------- drivers ----------------
    task automatic set_req(input bit k, input logic [1:0] op, input logic [2:0] len,
                           input logic [31:0] a, input logic [31:0] b);
        if (k) begin
            r1_op = op; r1_len = len; r1_dataa = a; r1_datab = b; r1_valid = 1'b1;
        end else begin
            r0_op = op; r0_len = len; r0_dataa = a; r0_datab = b; r0_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input bit k);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = k ? r1_ready : r0_ready;
        end
        chk(k ? "accept1" : "accept0", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (k) r1_valid = 1'b0;
        else   r0_valid = 1'b0;
    endtask

    task automatic finish_cmd(input bit k, output int lat);
        int  base;
        bit  got = 1'b0;
        wait_accept(k);
        base = rsp_cnt[k];
        lat = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            #1;
            lat++;
            got = (rsp_cnt[k] != base);
        end
        chk(k ? "response1" : "response0", 32'(got), 32'd1);
    endtask

    task automatic send(input bit k, input logic [1:0] op, input logic [2:0] len,
                        input logic [31:0] a, input logic [31:0] b, input bit tmo, output int lat);
        model_cmd(k, op, len, a, b, tmo);
        set_req(k, op, len, a, b);
        finish_cmd(k, lat);
    endtask

    task automatic pair_get();
        bit f;
        int l0, l1;
        f = mrr;
        model_cmd(f, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0);
        model_cmd(!f, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0);
        set_req(1'b0, 2'b10, 3'd0, 32'h0, 32'h0);
        set_req(1'b1, 2'b10, 3'd0, 32'h0, 32'h0);
        fork
            finish_cmd(1'b0, l0);
            finish_cmd(1'b1, l1);
        join
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, base;
        mctx[0] = CTX_INIT;
        mctx[1] = CTX_INIT;
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_eng_clk_en", 32'(eng_clk_en), 32'd0);
        chk("rst_rsp", 32'({r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // First owner: restore without save.
        send(1'b0, 2'b01, 3'd4, 32'h12345678, 32'h0, 1'b0, lat);
        chk("owner_r0", 32'(owner), 32'd2);

        // Ownership change: save, restore, exec.
        send(1'b1, 2'b01, 3'd1, 32'h000000AB, 32'h0, 1'b0, lat);
        chk("owner_r1", 32'(owner), 32'd3);
        send(1'b0, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0, lat);
        chk("get_nonowner_latency", 32'(lat), 32'd1);
        chk("owner_kept", 32'(owner), 32'd3);

        // Simultaneous requests, with single commands flipping the pointer between pairs.
        for (int p = 0; p < 4; p++) begin
            if (p % 2 == 1) send(1'b1, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0, lat);
            pair_get();
        end

        // Non-owner SET then UPDATE carries the set value into the restore.
        send(1'b0, 2'b00, 3'd0, 32'hDEADBEEF, 32'h0, 1'b0, lat);
        send(1'b0, 2'b01, 3'd2, 32'h0000CAFE, 32'h0, 1'b0, lat);
        chk("owner_r0_again", 32'(owner), 32'd2);
        send(1'b1, 2'b11, 3'd0, 32'h11111111, 32'h0, 1'b0, lat);
        send(1'b1, 2'b01, 3'd0, 32'h22222222, 32'h0, 1'b0, lat);
        send(1'b1, 2'b01, 3'd7, 32'h33333333, 32'h0, 1'b0, lat);
        send(1'b0, 2'b00, 3'd0, 32'h0BADF00D, 32'h0, 1'b0, lat);
        send(1'b0, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0, lat);
        send(1'b0, 2'b01, 3'd5, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, lat);

        // Engine never finishes.
        hang = 1'b1;
        send(1'b0, 2'b01, 3'd3, 32'h00ABCDEF, 32'h0, 1'b1, lat);
        @(negedge clk);
        chk("timeout_clk_en_cycles", 32'(last_run), 32'(TMO));
        chk("owner_after_timeout", 32'(owner), 32'd0);
        hang = 1'b0;
        send(1'b1, 2'b01, 3'd4, 32'hFEEDFACE, 32'h0, 1'b0, lat);
        chk("owner_r1_after_timeout", 32'(owner), 32'd3);

        // Reset while the engine is busy.
        hang = 1'b1;
        exp_grant.push_back(1'b1);
        exp_eng.push_back({3'd2, 32'h00001234});
        set_req(1'b1, 2'b01, 3'd2, 32'h00001234, 32'h0);
        wait_accept(1'b1);
        repeat (4) @(negedge clk);
        chk("pre_rst_clk_en", 32'(eng_clk_en), 32'd1);
        base = rsp_cnt[1];
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_eng", 32'({eng_clk_en, eng_start, eng_n}), 32'd0);
        chk("mid_rst_eng_data", eng_dataa | eng_datab, 32'd0);
        chk("mid_rst_busy_owner", 32'({busy, owner}), 32'd0);
        chk("mid_rst_rsp", 32'({r0_rsp_valid, r1_rsp_valid, r0_ready, r1_ready}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hang = 1'b0;
        mctx[0] = CTX_INIT;
        mctx[1] = CTX_INIT;
        mown = 2'b00;
        mrr = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_rsp_after_reset", 32'(rsp_cnt[1]), 32'(base));
        send(1'b0, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0, lat);
        send(1'b1, 2'b10, 3'd0, 32'h0, 32'h0, 1'b0, lat);
        send(1'b1, 2'b01, 3'd1, 32'h0000005C, 32'h0, 1'b0, lat);
        chk("owner_after_reset_update", 32'(owner), 32'd3);

        repeat (4) @(negedge clk);
        chk("eng_queue_empty", 32'(exp_eng.size()), 32'd0);
        chk("rsp_queues_empty", 32'(exp_rsp0.size() + exp_rsp1.size()), 32'd0);
        chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
